// File: rtl/shooter_pkg.sv
// Shared screen geometry, colour codes, compositor state and object snapshot
// types for the shooter display path.
package shooter_pkg;

   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;
   localparam int unsigned PIX_XW   = 8;
   localparam int unsigned PIX_YW   = 7;

   localparam logic [2:0] COL_BG     = 3'b000;
   localparam logic [2:0] COL_PLAYER = 3'b010;
   localparam logic [2:0] COL_ENEMY  = 3'b100;
   localparam logic [2:0] COL_BULLET = 3'b110;
   localparam logic [2:0] COL_BORDER = 3'b111;

   typedef enum logic [1:0] {
      CS_IDLE  = 2'd0,
      CS_SWEEP = 2'd1,
      CS_DONE  = 2'd2
   } comp_state_e;

   // Per-frame copy of every object input, frozen for the duration of a sweep.
   typedef struct packed {
      logic [PIX_XW-1:0] player_x;
      logic [PIX_YW-1:0] player_y;
      logic [PIX_XW-1:0] enemy_x;
      logic [PIX_YW-1:0] enemy_y;
      logic              enemy_alive;
      logic [PIX_XW-1:0] bullet_x;
      logic [PIX_YW-1:0] bullet_y;
      logic              bullet_active;
   } obj_snap_t;

endpackage

// File: rtl/frame_compositor_box_hit.sv
// box_hit: combinational test of a pixel against a W x H rectangle whose
// far edges are computed one bit wider so boxes clip instead of wrapping.
module box_hit
   import shooter_pkg::*;
#(
   parameter int unsigned W = 1,
   parameter int unsigned H = 1
) (
   input  logic [PIX_XW-1:0] px,
   input  logic [PIX_YW-1:0] py,
   input  logic [PIX_XW-1:0] ox,
   input  logic [PIX_YW-1:0] oy,
   output logic              hit
);

   localparam int unsigned XEW = PIX_XW + 1;
   localparam int unsigned YEW = PIX_YW + 1;

   logic [XEW-1:0] x_end_c;
   logic [YEW-1:0] y_end_c;

   assign x_end_c = XEW'(ox) + XEW'(W);
   assign y_end_c = YEW'(oy) + YEW'(H);

   assign hit = (px >= ox) && (XEW'(px) < x_end_c) &&
                (py >= oy) && (YEW'(py) < y_end_c);

endmodule

// File: rtl/frame_compositor.sv
// frame_compositor: colours the sweep's pixel stream from a per-frame object
// snapshot and counts frames. Define FRAME_BORDER_EN to colour the screen edge.
module frame_compositor
   import shooter_pkg::*;
#(
   parameter int unsigned PLAYER_W = 8,
   parameter int unsigned PLAYER_H = 6,
   parameter int unsigned ENEMY_W  = 10,
   parameter int unsigned ENEMY_H  = 8,
   parameter int unsigned BULLET_W = 1,
   parameter int unsigned BULLET_H = 3
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic              writeEn_in,
   input  logic              ld_in,
   input  logic [PIX_XW-1:0] x_in,
   input  logic [PIX_YW-1:0] y_in,
   input  logic [PIX_XW-1:0] player_x,
   input  logic [PIX_YW-1:0] player_y,
   input  logic [PIX_XW-1:0] enemy_x,
   input  logic [PIX_YW-1:0] enemy_y,
   input  logic              enemy_alive,
   input  logic [PIX_XW-1:0] bullet_x,
   input  logic [PIX_YW-1:0] bullet_y,
   input  logic              bullet_active,
   output logic [PIX_XW-1:0] x_out,
   output logic [PIX_YW-1:0] y_out,
   output logic [2:0]        colour,
   output logic              plot,
   output logic              frame_done,
   output logic [7:0]        frame_count
);

   comp_state_e       state_q, state_d;
   obj_snap_t         snap_q, snap_d;
   logic [PIX_XW-1:0] s1_x_q, s1_x_d;
   logic [PIX_YW-1:0] s1_y_q, s1_y_d;
   logic              s1_valid_q, s1_valid_d;
   logic [PIX_XW-1:0] x_out_q, x_out_d;
   logic [PIX_YW-1:0] y_out_q, y_out_d;
   logic [2:0]        colour_q, colour_d;
   logic              plot_q, plot_d;
   logic              frame_done_q, frame_done_d;
   logic [7:0]        frame_count_q, frame_count_d;

   logic              player_hit_c, enemy_box_c, bullet_box_c;

   // State register and all datapath flops.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q       <= CS_IDLE;
         snap_q        <= '0;
         s1_x_q        <= '0;
         s1_y_q        <= '0;
         s1_valid_q    <= 1'b0;
         x_out_q       <= '0;
         y_out_q       <= '0;
         colour_q      <= COL_BG;
         plot_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         snap_q        <= snap_d;
         s1_x_q        <= s1_x_d;
         s1_y_q        <= s1_y_d;
         s1_valid_q    <= s1_valid_d;
         x_out_q       <= x_out_d;
         y_out_q       <= y_out_d;
         colour_q      <= colour_d;
         plot_q        <= plot_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
      end
   end

   box_hit #(.W(PLAYER_W), .H(PLAYER_H)) u_player_hit (
      .px(s1_x_q), .py(s1_y_q), .ox(snap_q.player_x), .oy(snap_q.player_y),
      .hit(player_hit_c)
   );

   box_hit #(.W(ENEMY_W), .H(ENEMY_H)) u_enemy_hit (
      .px(s1_x_q), .py(s1_y_q), .ox(snap_q.enemy_x), .oy(snap_q.enemy_y),
      .hit(enemy_box_c)
   );

   box_hit #(.W(BULLET_W), .H(BULLET_H)) u_bullet_hit (
      .px(s1_x_q), .py(s1_y_q), .ox(snap_q.bullet_x), .oy(snap_q.bullet_y),
      .hit(bullet_box_c)
   );

`ifdef FRAME_BORDER_EN
   logic border_c;
   assign border_c = (s1_x_q == '0) || (s1_x_q == PIX_XW'(SCREEN_W - 1)) ||
                     (s1_y_q == '0) || (s1_y_q == PIX_YW'(SCREEN_H - 1));
`endif

   // Next-state, snapshot capture, pixel pipeline and frame bookkeeping.
   always_comb begin
      state_d       = state_q;
      snap_d        = snap_q;
      frame_count_d = frame_count_q;
      frame_done_d  = (state_q == CS_DONE);

      case (state_q)
         CS_IDLE: begin
            if (writeEn_in) begin
               state_d = CS_SWEEP;
               snap_d  = '{player_x: player_x, player_y: player_y,
                           enemy_x: enemy_x, enemy_y: enemy_y,
                           enemy_alive: enemy_alive,
                           bullet_x: bullet_x, bullet_y: bullet_y,
                           bullet_active: bullet_active};
            end
         end
         CS_SWEEP: begin
            if (ld_in) begin
               state_d       = CS_DONE;
               frame_count_d = frame_count_q + 8'd1;
            end
         end
         CS_DONE:  state_d = CS_IDLE;
         default:  state_d = CS_IDLE;
      endcase

      // The sweep's terminal y=SCREEN_H strobe is dropped here.
      s1_x_d     = x_in;
      s1_y_d     = y_in;
      s1_valid_d = writeEn_in && (x_in < PIX_XW'(SCREEN_W)) &&
                   (y_in < PIX_YW'(SCREEN_H));

      x_out_d = s1_x_q;
      y_out_d = s1_y_q;
      plot_d  = s1_valid_q;
      if (bullet_box_c && snap_q.bullet_active) begin
         colour_d = COL_BULLET;
      end else if (player_hit_c) begin
         colour_d = COL_PLAYER;
      end else if (enemy_box_c && snap_q.enemy_alive) begin
         colour_d = COL_ENEMY;
`ifdef FRAME_BORDER_EN
      end else if (border_c) begin
         colour_d = COL_BORDER;
`endif
      end else begin
         colour_d = COL_BG;
      end
   end

   assign x_out       = x_out_q;
   assign y_out       = y_out_q;
   assign colour      = colour_q;
   assign plot        = plot_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_compositor.sv
// Directed bench for frame_compositor: a frame-level reference model checked
// every cycle, plus hand-computed spot checks on key pixels and frame events.
module tb_frame_compositor;

   logic       clk, rst_n;
   logic       we, ld;
   logic [7:0] x_in, px, ex, bx;
   logic [6:0] y_in, py, ey, by;
   logic       ea, ba;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour;
   logic       plot, frame_done;
   logic [7:0] frame_count;

   int errors = 0;
   int checks = 0;

   frame_compositor dut (
      .CLOCK_50(clk), .resetn(rst_n), .writeEn_in(we), .ld_in(ld),
      .x_in(x_in), .y_in(y_in),
      .player_x(px), .player_y(py), .enemy_x(ex), .enemy_y(ey),
      .enemy_alive(ea), .bullet_x(bx), .bullet_y(by), .bullet_active(ba),
      .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot),
      .frame_done(frame_done), .frame_count(frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int phase;            // 0 waiting for a frame, 1 drawing, 2 frame just ended
   int frames;
   int s_px, s_py, s_ex, s_ey, s_bx, s_by;
   bit s_ea, s_ba;
   int m_x, m_y, m_col, c_x, c_y, c_col;
   bit m_plot, m_done, c_plot, c_done;

   function automatic bit in_box(int x, int y, int ox, int oy, int w, int h);
      return (x >= ox) && (x < ox + w) && (y >= oy) && (y < oy + h);
   endfunction

   function automatic int model_colour(int x, int y);
      if (s_ba && in_box(x, y, s_bx, s_by, 1, 3))  return 6;
      if (in_box(x, y, s_px, s_py, 8, 6))          return 2;
      if (s_ea && in_box(x, y, s_ex, s_ey, 10, 8)) return 4;
`ifdef FRAME_BORDER_EN
      if (x == 0 || x == 159 || y == 0 || y == 119) return 7;
`endif
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase = 0; frames = 0;
         s_px = 0; s_py = 0; s_ex = 0; s_ey = 0; s_bx = 0; s_by = 0;
         s_ea = 0; s_ba = 0;
         m_x = 0; m_y = 0; m_col = 0; m_plot = 0; m_done = 0;
         c_x = 0; c_y = 0; c_col = 0; c_plot = 0; c_done = 0;
      end else begin
         c_x = m_x; c_y = m_y; c_col = m_col; c_plot = m_plot; c_done = m_done;
         m_done = 0;
         if (phase == 0 && we) begin
            s_px = px; s_py = py; s_ex = ex; s_ey = ey; s_ea = ea;
            s_bx = bx; s_by = by; s_ba = ba;
         end
         m_x = x_in; m_y = y_in;
         m_plot = we && (x_in < 160) && (y_in < 120);
         m_col = model_colour(int'(x_in), int'(y_in));
         if (phase == 0) begin
            if (we) phase = 1;
         end else if (phase == 1) begin
            if (ld) begin
               phase = 2; frames = (frames + 1) % 256; m_done = 1;
            end
         end else begin
            phase = 0;
         end
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("plot", int'(plot), int'(c_plot));
         chk("frame_done", int'(frame_done), int'(c_done));
         chk("frame_count", int'(frame_count), frames);
         if (c_plot) begin
            chk("x_out", int'(x_out), c_x);
            chk("y_out", int'(y_out), c_y);
            chk("colour", int'(colour), c_col);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input int x, input int y, input bit w, input bit l);
      x_in = 8'(x); y_in = 7'(y); we = w; ld = l;
      @(negedge clk);
   endtask

   int border_col;

   initial begin
`ifdef FRAME_BORDER_EN
      border_col = 7;
`else
      border_col = 0;
`endif
      rst_n = 1'b0; we = 0; ld = 0; x_in = 0; y_in = 0;
      px = 8'd10; py = 7'd20; ex = 0; ey = 0; ea = 0; bx = 0; by = 0; ba = 0;
      @(negedge clk);
      chk("rst_plot", int'(plot), 0);
      chk("rst_colour", int'(colour), 0);
      chk("rst_frame_count", int'(frame_count), 0);
      rst_n = 1'b1;

      // Frame 1: player only
      drive(12, 22, 1, 0);
      drive(18, 22, 1, 0);
      chk("f1_x", int'(x_out), 12);
      chk("f1_y", int'(y_out), 22);
      chk("f1_player", int'(colour), 2);
      chk("f1_plot", int'(plot), 1);
      drive(0, 0, 0, 0);
      chk("f1_bg", int'(colour), 0);
      drive(0, 0, 0, 1);
      chk("f1_done_early", int'(frame_done), 0);
      chk("f1_count", int'(frame_count), 1);
      drive(0, 0, 0, 0);
      chk("f1_done", int'(frame_done), 1);
      drive(0, 0, 0, 0);
      chk("f1_done_off", int'(frame_done), 0);

      // Frame 2: bullet over player, player moves mid-frame
      bx = 8'd12; by = 7'd21; ba = 1;
      drive(12, 22, 1, 0);
      px = 8'd100;
      drive(11, 23, 1, 0);
      chk("f2_bullet", int'(colour), 6);
      drive(0, 0, 0, 0);
      chk("f2_snapshot", int'(colour), 2);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);

      // Frame 3: enemy clipped at right edge, terminal strobe, border
      ba = 0; ex = 8'd155; ey = 7'd0; ea = 1;
      drive(0, 0, 1, 0);
      drive(159, 0, 1, 0);
      chk("f3_no_wrap", int'(colour), border_col);
      drive(0, 120, 1, 0);
      chk("f3_enemy_clip", int'(colour), 4);
      drive(0, 50, 1, 0);
      chk("f3_terminal_noplot", int'(plot), 0);
      drive(0, 0, 0, 1);
      chk("f3_border", int'(colour), border_col);
      drive(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
      chk("idle_ld_nopulse", int'(frame_done), 0);
      chk("idle_ld_count", int'(frame_count), 3);

      // Frame 4: overlapping objects, last pixel with ld, pixel in DONE
      px = 8'd10; py = 7'd20; ex = 8'd14; ey = 7'd22; ea = 1;
      bx = 8'd15; by = 7'd19; ba = 1;
      for (int y = 17; y <= 30; y++)
         for (int x = 6; x <= 26; x++) drive(x, y, 1, 0);
      drive(27, 30, 1, 1);
      px = 8'd50;
      drive(12, 22, 1, 0);
      drive(0, 0, 0, 0);
      chk("f4_done_pixel", int'(colour), 2);
      drive(0, 0, 0, 0);

      // 252 more frames wrap the counter to zero
      for (int f = 0; f < 252; f++) begin
         drive(1, 1, 1, 0);
         drive(2, 1, 1, 1);
         drive(0, 0, 0, 0);
      end
      chk("count_wrap", int'(frame_count), 0);
      drive(1, 1, 1, 0);
      drive(2, 1, 1, 1);
      drive(0, 0, 0, 0);

      // Reset mid-sweep
      drive(3, 3, 1, 0);
      drive(4, 4, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_plot", int'(plot), 0);
      chk("mid_rst_x", int'(x_out), 0);
      chk("mid_rst_count", int'(frame_count), 0);
      @(negedge clk);
      drive(5, 5, 1, 0);
      rst_n = 1'b1;
      drive(6, 6, 0, 1);
      drive(6, 6, 0, 1);
      drive(6, 6, 0, 1);
      chk("post_rst_plot", int'(plot), 0);
      chk("post_rst_done", int'(frame_done), 0);
      drive(7, 7, 1, 0);
      drive(0, 0, 0, 0);
      chk("post_rst_new_plot", int'(plot), 1);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
